// File: rtl/mem_pkg.sv
// mem_pkg: shared types and widths for the memory / write-back stage
package mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 24;
  localparam int REG_W = 24;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0] wa3;
    logic reg_write;
    logic pc_src;
  } wb_t;
endpackage

// File: rtl/mem_wb_timer.sv
// mem_wb_timer: counts BUSY cycles and flags expiry on the LIMIT-th cycle
module mem_wb_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] count;
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en) count <= count + 1'b1;
  end
  assign expired = en && (count == CW'(LIMIT - 1));
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory req/ack controller and MEM/WB register; MEM_TIMEOUT_EN adds a BUSY abort timer
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] WD,
  input  logic [REG_W-1:0]  WA3M,
  input  logic              PCSrcM,
  input  logic              regWriteM,
  input  logic              memWriteM,
  input  logic              memToRegM,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memAck,
  output logic              stallM,
  output logic [DATA_W-1:0] resultW,
  output logic [REG_W-1:0]  WA3W,
  output logic              regWriteW,
  output logic              PCSrcW,
  output logic              memErr
);
  state_t state, state_nxt;
  wb_t wb, wb_nxt;
  logic access, busy, accept, done, abort;
  logic [ADDR_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_wd;
  logic [REG_W-1:0] lat_wa3;
  logic lat_pcs, lat_rw, lat_mw, lat_m2r;
  assign access = memWriteM | memToRegM;
  assign busy = state == BUSY;
  assign accept = !busy && access;
  assign done = busy && memAck;
`ifdef MEM_TIMEOUT_EN
  logic expired;
  mem_wb_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en(busy),
    .expired(expired)
  );
  // an ack arriving in the expiry cycle still completes the access
  assign abort = expired && !memAck;
  always_ff @(posedge clk) begin
    if (rst) memErr <= 1'b0;
    else if (abort) memErr <= 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign abort = 1'b0;
  assign memErr = 1'b0;
`endif
  always_comb begin
    state_nxt = busy ? ((memAck || abort) ? IDLE : BUSY) : (access ? BUSY : IDLE);
    wb_nxt = '0;
    if (!busy && !access)
      wb_nxt = '{result: {(DATA_W-ADDR_W)'(0), A}, wa3: WA3M, reg_write: regWriteM, pc_src: PCSrcM};
    else if (done)
      wb_nxt = '{result: lat_m2r ? memRData : {(DATA_W-ADDR_W)'(0), lat_a},
                 wa3: lat_wa3, reg_write: lat_rw, pc_src: lat_pcs};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wb <= '0;
      lat_a <= '0;
      lat_wd <= '0;
      lat_wa3 <= '0;
      {lat_pcs, lat_rw, lat_mw, lat_m2r} <= '0;
    end else begin
      state <= state_nxt;
      wb <= wb_nxt;
      if (accept) begin
        lat_a <= A;
        lat_wd <= WD;
        lat_wa3 <= WA3M;
        {lat_pcs, lat_rw, lat_mw, lat_m2r} <= {PCSrcM, regWriteM, memWriteM, memToRegM};
      end
    end
  end
  assign stallM = busy ? (!memAck && !abort) : access;
  assign memReq = busy;
  assign memWe = busy && lat_mw;
  assign memAddr = lat_a;
  assign memWData = lat_wd;
  assign resultW = wb.result;
  assign WA3W = wb.wa3;
  assign regWriteW = wb.reg_write;
  assign PCSrcW = wb.pc_src;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vectors with a per-cycle write-back scoreboard
module tb_mem_wb_stage;
  logic clk, rst;
  logic [15:0] A, memAddr;
  logic [23:0] WD, WA3M, memWData, memRData, resultW, WA3W;
  logic PCSrcM, regWriteM, memWriteM, memToRegM;
  logic memReq, memWe, memAck, stallM, regWriteW, PCSrcW, memErr;
  typedef struct {
    logic bub;
    logic [23:0] r;
    logic [23:0] w;
    logic rw;
    logic pc;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .A(A), .WD(WD), .WA3M(WA3M),
    .PCSrcM(PCSrcM), .regWriteM(regWriteM), .memWriteM(memWriteM), .memToRegM(memToRegM),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memAck(memAck), .stallM(stallM),
    .resultW(resultW), .WA3W(WA3W), .regWriteW(regWriteW), .PCSrcW(PCSrcW), .memErr(memErr)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic exp_t wbv(input logic [23:0] r, input logic [23:0] w, input logic rw, input logic pc);
    return '{bub: 1'b0, r: r, w: w, rw: rw, pc: pc};
  endfunction

  function automatic exp_t bb();
    return '{bub: 1'b1, r: 24'h0, w: 24'h0, rw: 1'b0, pc: 1'b0};
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("regWriteW", regWriteW, e.rw);
        chk("PCSrcW", PCSrcW, e.pc);
        if (!e.bub) begin
          chk("resultW", resultW, e.r);
          chk("WA3W", WA3W, e.w);
        end
      end
    end
  end

  task automatic drv(input logic [15:0] a, input logic [23:0] wd, input logic [23:0] wa3,
                     input logic pcs, input logic rw, input logic mw, input logic m2r,
                     input logic ack, input logic [23:0] rd);
    A = a; WD = wd; WA3M = wa3; PCSrcM = pcs; regWriteM = rw;
    memWriteM = mw; memToRegM = m2r; memAck = ack; memRData = rd;
  endtask

  task automatic nop(input logic ack, input logic [23:0] rd);
    drv(16'h0, 24'h0, 24'h0, 0, 0, 0, 0, ack, rd);
  endtask

  task automatic step(input logic es, input logic er, input logic ewe, input exp_t e);
    #1;
    chk("stallM", stallM, es);
    chk("memReq", memReq, er);
    chk("memWe", memWe, ewe);
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    nop(0, 0);
    q.push_back(wbv(0, 0, 0, 0));
    @(negedge clk);
    #1;
    chk("rst memAddr", memAddr, 0);
    chk("rst memWData", memWData, 0);
    chk("rst memErr", memErr, 0);
    step(0, 0, 0, wbv(0, 0, 0, 0));
    rst = 0;
    drv(16'h1234, 0, 24'h5, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, wbv(24'h001234, 24'h5, 1, 0));
    nop(0, 0);
    step(0, 0, 0, wbv(0, 0, 0, 0));
    // load, ack after three idle BUSY cycles
    drv(16'h0040, 0, 24'h7, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, bb());
    #1 chk("load memAddr", memAddr, 24'h0040);
    step(1, 1, 0, bb());
    step(1, 1, 0, bb());
    step(1, 1, 0, bb());
    drv(16'h0040, 0, 24'h7, 0, 1, 0, 1, 1, 24'hABCDEF);
    step(0, 1, 0, wbv(24'hABCDEF, 24'h7, 1, 0));
    nop(1, 24'h777777);
    step(0, 0, 0, wbv(0, 0, 0, 0));
    // store, immediate ack
    drv(16'h0080, 24'h00FF00, 24'h9, 1, 0, 1, 0, 0, 0);
    step(1, 0, 0, bb());
    drv(16'h0080, 24'h00FF00, 24'h9, 1, 0, 1, 0, 1, 24'h555555);
    #1;
    chk("store memWData", memWData, 24'h00FF00);
    chk("store memAddr", memAddr, 24'h0080);
    step(0, 1, 1, wbv(24'h000080, 24'h9, 0, 1));
    // back-to-back load then store
    drv(16'h0010, 0, 24'h3, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, bb());
    drv(16'h0010, 0, 24'h3, 0, 1, 0, 1, 1, 24'h111111);
    step(0, 1, 0, wbv(24'h111111, 24'h3, 1, 0));
    drv(16'h0020, 24'h222222, 24'h4, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, bb());
    drv(16'h0020, 24'h222222, 24'h4, 0, 0, 1, 0, 1, 0);
    #1 chk("b2b memWData", memWData, 24'h222222);
    step(0, 1, 1, wbv(24'h000020, 24'h4, 0, 0));
    nop(0, 0);
    step(0, 0, 0, wbv(0, 0, 0, 0));
    // reset in the second BUSY cycle, then a late ack
    drv(16'h0050, 0, 24'h6, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, bb());
    step(1, 1, 0, bb());
    rst = 1;
    step(1, 1, 0, wbv(0, 0, 0, 0));
    rst = 0;
    nop(1, 24'h333333);
    #1 chk("post-rst memAddr", memAddr, 0);
    step(0, 0, 0, wbv(0, 0, 0, 0));
    nop(0, 0);
    step(0, 0, 0, wbv(0, 0, 0, 0));
    // long wait: aborts with the timer, otherwise waits for ack
    drv(16'h0060, 0, 24'h8, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, bb());
`ifdef MEM_TIMEOUT_EN
    step(1, 1, 0, bb());
    step(1, 1, 0, bb());
    step(1, 1, 0, bb());
    step(0, 1, 0, bb());
    nop(0, 0);
    #1 chk("memErr set", memErr, 1);
    step(0, 0, 0, wbv(0, 0, 0, 0));
    #1 chk("memErr sticky", memErr, 1);
    rst = 1;
    step(0, 0, 0, wbv(0, 0, 0, 0));
    rst = 0;
    #1 chk("memErr cleared", memErr, 0);
    step(0, 0, 0, wbv(0, 0, 0, 0));
`else
    for (int i = 0; i < 6; i++) step(1, 1, 0, bb());
    drv(16'h0060, 0, 24'h8, 0, 1, 0, 1, 1, 24'h444444);
    step(0, 1, 0, wbv(24'h444444, 24'h8, 1, 0));
    nop(0, 0);
    #1 chk("memErr off", memErr, 0);
    step(0, 0, 0, wbv(0, 0, 0, 0));
`endif
    @(posedge clk);
    #2;
    chk("queue drained", 24'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
